// File: rtl/alu_seq_if.sv
// Operand/result bundle for alu_seq: input and output valid/ready channels.
// The decode/writeback side uses master; the ALU uses slave.
interface alu_seq_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ctrl_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result_o;
    logic [WIDTH-1:0] prod_hi_o;
    logic             zero_o;
    logic             cout_o;
    logic             overflow_o;
    logic             err_o;

    modport master (
        output in_valid, src1_i, src2_i, ctrl_i, out_ready,
        input  in_ready, out_valid, result_o, prod_hi_o,
               zero_o, cout_o, overflow_o, err_o
    );

    modport slave (
        input  in_valid, src1_i, src2_i, ctrl_i, out_ready,
        output in_ready, out_valid, result_o, prod_hi_o,
               zero_o, cout_o, overflow_o, err_o
    );

endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arithmetic ops and a WIDTH-cycle
// unsigned shift-add multiplier, with registered, handshaked results.
module alu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic       clk_i,
    input  logic       rst_i,
    alu_seq_if.slave   bus,
    output logic [1:0] dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high. in_ready is high only in IDLE; out_valid is high only in DONE
    // and the result registers never change while it is high.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     sum;
    logic               ovf_raw;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_cout;
    logic               alu_ovf;
    logic               alu_err;

    logic [2*WIDTH-1:0] addend;
    logic [2*WIDTH-1:0] acc_next;

    assign bus.in_ready = (state == S_IDLE);
    assign dbg_state    = state;

    // Slice semantics: optional invert on each operand, B_invert doubles as
    // carry-in so SUB/SLT form A + ~B + 1.
    always_comb begin
        op_a    = bus.ctrl_i[3] ? ~bus.src1_i : bus.src1_i;
        op_b    = bus.ctrl_i[2] ? ~bus.src2_i : bus.src2_i;
        sum     = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, bus.ctrl_i[2]};
        ovf_raw = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);

        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        case (bus.ctrl_i)
            OP_AND, OP_NOR: alu_res = op_a & op_b;
            OP_OR:          alu_res = op_a | op_b;
            OP_ADD, OP_SUB: begin
                alu_res  = sum[WIDTH-1:0];
                alu_cout = sum[WIDTH];
                alu_ovf  = ovf_raw;
            end
            // Sign of the true difference, valid even when A-B overflows.
            OP_SLT:         alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
            OP_MUL:         alu_res = '0;
            default:        alu_err = 1'b1;
        endcase
    end

    always_comb begin
        addend   = mplier[cnt] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
        acc_next = acc + addend;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= S_IDLE;
            mcand          <= '0;
            mplier         <= '0;
            acc            <= '0;
            cnt            <= '0;
            bus.out_valid  <= 1'b0;
            bus.result_o   <= '0;
            bus.prod_hi_o  <= '0;
            bus.zero_o     <= 1'b0;
            bus.cout_o     <= 1'b0;
            bus.overflow_o <= 1'b0;
            bus.err_o      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.ctrl_i == OP_MUL) begin
                            mcand  <= bus.src1_i;
                            mplier <= bus.src2_i;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= S_MUL;
                        end else begin
                            bus.result_o   <= alu_res;
                            bus.prod_hi_o  <= '0;
                            bus.zero_o     <= (alu_res == '0);
                            bus.cout_o     <= alu_cout;
                            bus.overflow_o <= alu_ovf;
                            bus.err_o      <= alu_err;
                            bus.out_valid  <= 1'b1;
                            state          <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        bus.result_o   <= acc_next[WIDTH-1:0];
                        bus.prod_hi_o  <= acc_next[2*WIDTH-1:WIDTH];
                        bus.zero_o     <= (acc_next[WIDTH-1:0] == '0);
                        bus.cout_o     <= 1'b0;
                        bus.overflow_o <= |acc_next[2*WIDTH-1:WIDTH];
                        bus.err_o      <= 1'b0;
                        bus.out_valid  <= 1'b1;
                        state          <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: vector table, random ops against a reference
// model, backpressure and mid-multiply reset sequences.
module tb_alu_seq;

    localparam int W     = 8;
    localparam int EXP_W = 2 * W + 4;
    localparam int SMAX  = 2 ** (W - 1) - 1;
    localparam int SMIN  = -(2 ** (W - 1));
    localparam int UMAX  = 2 ** W - 1;
    localparam int NVEC  = 17;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   ctrl;
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         zero;
        logic         cout;
        logic         ovf;
        logic         err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    vec_t             vecs[NVEC];
    logic [EXP_W-1:0] exp_q[$];
    logic [3:0]       codes[8];
    int               tests = 0;
    int               fails = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checks / model ----------------
    task automatic check_v(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    function automatic logic [EXP_W-1:0] pack(input vec_t v);
        return {v.res, v.hi, v.zero, v.cout, v.ovf, v.err};
    endfunction

    function automatic logic [EXP_W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic [3:0] ctrl);
        int ua, ub, sa, sb, u, s;
        logic [W-1:0]   res, hi;
        logic [2*W-1:0] p;
        logic           zero, cout, ovf, err;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        res = '0; hi = '0; cout = 1'b0; ovf = 1'b0; err = 1'b0;
        case (ctrl)
            4'h0: res = a & b;
            4'h1: res = a | b;
            4'h2: begin
                u = ua + ub; res = W'(u); cout = (u > UMAX);
                s = sa + sb; ovf = (s > SMAX) || (s < SMIN);
            end
            4'h6: begin
                res = a - b; cout = (ua >= ub);
                s = sa - sb; ovf = (s > SMAX) || (s < SMIN);
            end
            4'h7: res = (sa < sb) ? W'(1) : W'(0);
            4'hC: res = ~(a | b);
            4'h3: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                res = p[W-1:0]; hi = p[2*W-1:W]; ovf = (hi != '0);
            end
            default: err = 1'b1;
        endcase
        zero = (res == '0);
        return {res, hi, zero, cout, ovf, err};
    endfunction

    // ---------------- driver ----------------
    // Returns #1 after the accept edge with inputs scrambled and in_valid low.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] ctrl,
                         input logic [EXP_W-1:0] exp);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.src1_i   = a;
        bus.src2_i   = b;
        bus.ctrl_i   = ctrl;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard == 100) begin
            tests++; fails++;
            $display("FAIL issue_timeout: in_ready low for %0d cycles, required high", guard);
        end
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        bus.in_valid = 1'b0;
        bus.src1_i   = W'($urandom_range(0, UMAX));
        bus.src2_i   = W'($urandom_range(0, UMAX));
        bus.ctrl_i   = 4'($urandom_range(0, 15));
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic collect(input int exp_lat, input int hold);
        int n, leak;
        logic [EXP_W-1:0] e;
        n = 0; leak = 0; e = '0;
        @(negedge clk);
        while (!bus.out_valid && n < 64) begin
            if (bus.in_ready) leak++;
            @(negedge clk);
            n++;
        end
        check_v("latency", W'(n), W'(exp_lat));
        check_v("in_ready_busy_cycles", W'(leak), W'(0));
        check_b("in_ready_in_done", bus.in_ready, 1'b0);
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard: output seen with 0 expected entries, required 1");
        end else begin
            e = exp_q.pop_front();
            check_v("result", bus.result_o, e[EXP_W-1 -: W]);
            check_v("prod_hi", bus.prod_hi_o, e[W+3 -: W]);
            check_b("zero", bus.zero_o, e[3]);
            check_b("cout", bus.cout_o, e[2]);
            check_b("overflow", bus.overflow_o, e[1]);
            check_b("err", bus.err_o, e[0]);
        end
        repeat (hold) begin
            @(negedge clk);
            check_b("hold_out_valid", bus.out_valid, 1'b1);
            check_v("hold_result", bus.result_o, e[EXP_W-1 -: W]);
            check_b("hold_in_ready", bus.in_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check_b("out_valid_after_release", bus.out_valid, 1'b0);
        check_b("in_ready_after_release", bus.in_ready, 1'b1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vecs[0]  = '{8'h7F, 8'h01, 4'h2, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{8'h05, 8'h05, 4'h6, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{8'h80, 8'h7F, 4'h7, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{8'hFF, 8'hFF, 4'h3, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{8'hF0, 8'h3C, 4'h0, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'h0F, 8'hF0, 4'h1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{8'h0F, 8'hF0, 4'hC, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{8'hAA, 8'h55, 4'hF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{8'hFF, 8'h01, 4'h2, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{8'h00, 8'h01, 4'h6, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{8'h80, 8'h01, 4'h6, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{8'h7F, 8'h80, 4'h7, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{8'h01, 8'h02, 4'h7, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{8'h10, 8'h0F, 4'h3, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{8'h12, 8'h34, 4'h3, 8'hA8, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{8'h12, 8'h34, 4'h4, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{8'h80, 8'h80, 4'h2, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
        codes[0] = 4'h0; codes[1] = 4'h1; codes[2] = 4'h2; codes[3] = 4'h6;
        codes[4] = 4'h7; codes[5] = 4'hC; codes[6] = 4'h3; codes[7] = 4'h9;

        // reset state
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.src1_i    = '0;
        bus.src2_i    = '0;
        bus.ctrl_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        check_b("reset_in_ready", bus.in_ready, 1'b1);
        check_b("reset_out_valid", bus.out_valid, 1'b0);
        check_v("reset_result", bus.result_o, 8'h00);
        check_v("reset_prod_hi", bus.prod_hi_o, 8'h00);
        check_b("reset_err", bus.err_o, 1'b0);
        check_v("reset_state", W'(dbg_state), W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // vector table
        for (int i = 0; i < NVEC; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].ctrl, pack(vecs[i]));
            collect((vecs[i].ctrl == 4'h3) ? W : 0, 0);
        end

        // backpressure: AND held 5 cycles while an OR waits with in_valid high
        issue(8'hF0, 8'h3C, 4'h0, pack(vecs[4]));
        bus.src1_i   = 8'h0F;
        bus.src2_i   = 8'hF0;
        bus.ctrl_i   = 4'h1;
        bus.in_valid = 1'b1;
        collect(0, 5);
        @(posedge clk);
        exp_q.push_back(pack(vecs[5]));
        #1;
        bus.in_valid = 1'b0;
        collect(0, 0);

        // reset in the third cycle of a multiply
        issue(8'hFF, 8'hFF, 4'h3, pack(vecs[3]));
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_b("mid_mul_reset_out_valid", bus.out_valid, 1'b0);
        check_v("mid_mul_reset_result", bus.result_o, 8'h00);
        check_v("mid_mul_reset_prod_hi", bus.prod_hi_o, 8'h00);
        check_b("mid_mul_reset_overflow", bus.overflow_o, 1'b0);
        check_b("mid_mul_reset_in_ready", bus.in_ready, 1'b1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(negedge clk);
            check_b("post_reset_no_stale_valid", bus.out_valid, 1'b0);
        end
        issue(8'h0F, 8'hF0, 4'hC, pack(vecs[6]));
        collect(0, 0);

        // random ops against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] ra, rb;
            logic [3:0]   rc;
            ra = W'($urandom_range(0, UMAX));
            rb = W'($urandom_range(0, UMAX));
            rc = codes[$urandom_range(0, 7)];
            issue(ra, rb, rc, model(ra, rb, rc));
            collect((rc == 4'h3) ? W : 0, $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised WIDTH-bit ALU built on the team's per-bit ALU slice semantics: A/B invert, AND, OR, ADD, SUB, SLT and NOR.
- Adds a multi-cycle unsigned shift-add multiplier.
- Operands are captured through a valid/ready input handshake. Result and flags are held registered until consumed on a valid/ready output handshake.
- Sits between the decode stage and writeback of the single-issue datapath. The decode stage stalls on in_ready.

Parameters:
- WIDTH, 32, operand/result width in bits (>= 4).
- CNT_W, $clog2(WIDTH), multiplier iteration counter width.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operands and ctrl are valid.
- in_ready  output  1  block can accept an operation.
- src1_i  input  WIDTH  operand A.
- src2_i  input  WIDTH  operand B.
- ctrl_i  input  4  [3]=A_invert, [2]=B_invert, [1:0]=operation.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result_o  output  WIDTH  result (MUL: low half of product).
- prod_hi_o  output  WIDTH  high half of product (MUL only, else 0).
- zero_o  output  1  result_o == 0.
- cout_o  output  1  carry out of MSB (ADD/SUB only).
- overflow_o  output  1  signed overflow (ADD/SUB); MUL: prod_hi != 0.
- err_o  output  1  illegal ctrl code.

Behaviour:
- Encoding (ctrl_i):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (A + ~B + 1), 0111 SLT (signed), 1100 NOR (~A & ~B), 0011 MUL (unsigned).
  - All other codes are illegal.
- Reset:
  - state=IDLE, in_ready=1 (combinational from state).
  - All outputs, including out_valid, are 0. Counter and operand registers are 0.
  - Reset asserted mid-MUL aborts the operation immediately. No output is produced.
- FSM states are IDLE, MUL and DONE.
  - in_ready = (state==IDLE). Accept = in_valid & in_ready on a rising edge. src1_i/src2_i/ctrl_i are sampled on that edge only. Input changes while not IDLE are ignored.
  - IDLE + accept, non-MUL code: compute and register result/flags, go to DONE. out_valid is visible in the next cycle (latency 1).
  - IDLE + accept, MUL: load the multiplicand, multiplier and a 2*WIDTH accumulator = 0, set cnt=0, go to MUL.
  - MUL, each edge: if multiplier[cnt], accumulator += multiplicand << cnt; cnt++. When cnt==WIDTH-1 is processed, go to DONE. out_valid is visible exactly WIDTH cycles after the accept edge.
  - DONE: out_valid=1 and outputs stable. On out_valid & out_ready, go to IDLE; out_valid drops in the next cycle.
  - Throughput is at most one op per 2 cycles. There is no accept in the same cycle as a DONE handshake.
- Arithmetic and flags:
  - cout is the carry out of bit WIDTH-1. For SUB, cout=1 means no borrow.
  - ADD/SUB overflow = (a_msb==b'_msb) & (sum_msb!=a_msb), where b' is the post-invert operand.
  - SLT result = 1 iff src1 < src2 signed. This must be correct even when A-B overflows: use sum_msb ^ overflow. SLT cout and overflow are 0.
  - AND/OR/NOR: cout, overflow and prod_hi are 0.
  - MUL: result_o = product[WIDTH-1:0], prod_hi_o = product[2*WIDTH-1:WIDTH], overflow_o = |prod_hi, cout_o = 0.
  - zero_o is always derived from result_o.
  - Illegal code: result 0, zero_o=1, err_o=1, latency 1. All other ops drive err_o=0.
- When out_valid=0, output values are don't-care but must hold their last registered values, with no combinational path from the inputs.

Test Plan:
- WIDTH=8, ADD 0x7F + 0x01 (ctrl 0010) -> 1 cycle later out_valid=1, result=0x80, overflow=1, cout=0, zero=0.
- SUB 0x05 - 0x05 -> result=0x00, zero=1, cout=1. SLT 0x80 vs 0x7F -> result=0x01, despite the overflowing difference.
- MUL 0xFF * 0xFF -> out_valid asserted exactly 8 cycles after accept, result=0x01, prod_hi=0xFE, overflow=1, in_ready=0 throughout.
- Backpressure: hold out_ready=0 for 5 cycles after AND 0xF0 & 0x3C -> result stays 0x30 and out_valid stays 1. No new op is accepted while in_valid is held high. The op is accepted the cycle after the out_ready handshake.
- Reset (rst_i=0) asserted asynchronously at cycle 3 of a MUL -> all outputs 0 immediately, in_ready=1 after release, no stale out_valid. A following NOR 0x0F,0xF0 -> result=0x00, zero=1.
- Illegal ctrl 1111 -> err=1, result=0; the next legal op returns err=0.
